// File: rtl/tinyqv_mem_pkg.sv
// tinyqv_mem_pkg: access-size encodings, responder states and byte-lane helpers
package tinyqv_mem_pkg;
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER} state_t;
  function automatic logic is_byte(input logic [2:0] op);
    return op == MEM_B || op == MEM_BU;
  endfunction
  function automatic logic is_half(input logic [2:0] op);
    return op == MEM_H || op == MEM_HU;
  endfunction
  function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] lane);
    return op == MEM_W ? 4'hf : is_half(op) ? (lane[1] ? 4'hc : 4'h3) : is_byte(op) ? 4'b0001 << lane : 4'h0;
  endfunction
  function automatic logic [31:0] lane_shift(input logic [2:0] op, input logic [1:0] lane, input logic [31:0] w);
    return is_byte(op) ? w >> {lane, 3'b000} : is_half(op) ? w >> {lane[1], 4'b0000} : w;
  endfunction
endpackage

// File: rtl/tinyqv_mem_responder_if.sv
// tinyqv_mem_responder_if: nibble-serial load/store port between core and responder
interface tinyqv_mem_responder_if;
  logic [2:0] counter;
  logic [27:0] addr_in;
  logic address_ready;
  logic is_load;
  logic is_store;
  logic [2:0] mem_op;
  logic [3:0] store_data;
  logic [3:0] load_data;
  logic load_data_ready;
  logic busy;
  logic err;
  modport master (output counter, addr_in, address_ready, is_load, is_store, mem_op, store_data,
                  input load_data, load_data_ready, busy, err);
  modport slave (input counter, addr_in, address_ready, is_load, is_store, mem_op, store_data,
                 output load_data, load_data_ready, busy, err);
endinterface

// File: rtl/tinyqv_mem_array.sv
// tinyqv_mem_array: DEPTH x 32 RAM with byte-enable synchronous write and asynchronous read
module tinyqv_mem_array #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic we,
  input  logic [3:0] be,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [31:0] wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [31:0] rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[ridx];
endmodule

// File: rtl/tinyqv_mem_responder.sv
// tinyqv_mem_responder: register-file memory region answering TinyQV nibble-serial loads and stores
module tinyqv_mem_responder
  import tinyqv_mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter logic [3:0] BASE_HI = 4'h1,
  parameter int LATENCY = 0
) (
  input logic clk,
  input logic rstn,
  tinyqv_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [1:0] wcnt;
  logic [AW-1:0] idx, ridx;
  logic [1:0] lane, cur_lane;
  logic [2:0] op, cur_op;
  logic [27:0] sr;
  logic [31:0] wdata, rdata, word, store_word;
  logic err_q, req, ld, st, enter, last;
  logic unused_addr;
  assign unused_addr = ^bus.addr_in[23:AW+2];
  assign wdata = {bus.store_data, sr};
  assign req = bus.address_ready && bus.addr_in[27:24] == BASE_HI && bus.counter == 3'd7;
  assign ld = req && state == ST_IDLE && bus.is_load;
  assign st = req && state == ST_IDLE && bus.is_store && !bus.is_load && rstn;
  assign last = bus.counter == 3'd7;
  assign enter = (ld && LATENCY == 0) || (state == ST_WAIT && last && wcnt == 2'd1);
  assign ridx = state == ST_IDLE ? bus.addr_in[AW+1:2] : idx;
  assign cur_lane = state == ST_IDLE ? bus.addr_in[1:0] : lane;
  assign cur_op = state == ST_IDLE ? bus.mem_op : op;
  assign store_word = is_byte(bus.mem_op) ? {4{wdata[7:0]}} : is_half(bus.mem_op) ? {2{wdata[15:0]}} : wdata;
  tinyqv_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(st),
    .be(lane_mask(bus.mem_op, bus.addr_in[1:0])),
    .widx(bus.addr_in[AW+1:2]),
    .wdata(store_word),
    .ridx(ridx),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    sr <= wdata[31:4];
    if (!rstn) begin
      state <= ST_IDLE;
      wcnt <= 2'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= req && state != ST_IDLE;
      if (enter) word <= lane_shift(cur_op, cur_lane, rdata);
      if (ld) begin
        idx <= bus.addr_in[AW+1:2];
        lane <= bus.addr_in[1:0];
        op <= bus.mem_op;
        wcnt <= 2'(LATENCY);
        state <= LATENCY == 0 ? ST_XFER : ST_WAIT;
      end else if (state == ST_WAIT && last) begin
        wcnt <= wcnt - 2'd1;
        if (wcnt == 2'd1) state <= ST_XFER;
      end else if (state == ST_XFER && last) state <= ST_IDLE;
    end
  end
  assign bus.load_data_ready = state == ST_XFER;
  assign bus.load_data = state == ST_XFER ? word[{bus.counter, 2'b00} +: 4] : 4'h0;
  assign bus.busy = state != ST_IDLE;
  assign bus.err = err_q;
endmodule

// File: tb/tb_tinyqv_mem_responder.sv
// tb_tinyqv_mem_responder: directed checks of LATENCY 0 and 2 responders against a cycle-count byte model
module tb_tinyqv_mem_responder;
  import tinyqv_mem_pkg::*;
  logic clk = 0, rstn = 0, ar = 0, ld = 0, st = 0;
  logic [2:0] counter = 0, op = 0;
  logic [27:0] addr = 0;
  logic [3:0] sd = 0;
  logic [31:0] mw = 0;
  int vectors = 0, miscompares = 0, lastwait = 0, cyc = 0;
  int lat [2] = '{0, 2};
  always #5 clk = ~clk;
  always @(posedge clk) counter <= counter + 3'd1;
  tinyqv_mem_responder_if b0 (), b2 ();
  assign b0.counter = counter;
  assign b0.addr_in = addr;
  assign b0.address_ready = ar;
  assign b0.is_load = ld;
  assign b0.is_store = st;
  assign b0.mem_op = op;
  assign b0.store_data = sd;
  assign b2.counter = counter;
  assign b2.addr_in = addr;
  assign b2.address_ready = ar;
  assign b2.is_load = ld;
  assign b2.is_store = st;
  assign b2.mem_op = op;
  assign b2.store_data = sd;
  tinyqv_mem_responder #(.DEPTH(16), .BASE_HI(4'h1), .LATENCY(0)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
  tinyqv_mem_responder #(.DEPTH(16), .BASE_HI(4'h1), .LATENCY(2)) u2 (.clk(clk), .rstn(rstn), .bus(b2));
  logic [7:0] mb [2][64];
  bit act [2], eerr [2];
  int xs [2], xe [2];
  logic [5:0] la [2];
  logic [2:0] lop [2];
  logic [31:0] ew [2];
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      bit bp;
      logic [5:0] b;
      logic [31:0] w;
      bp = act[k] && (cyc - 1) <= xe[k];
      act[k] = bp;
      eerr[k] = 0;
      if (!rstn) act[k] = 0;
      else if (ar && addr[27:24] == 4'h1 && counter == 3'd7) begin
        if (bp) eerr[k] = 1;
        else if (ld) begin
          act[k] = 1;
          xs[k] = cyc + 8 * lat[k];
          xe[k] = xs[k] + 7;
          la[k] = addr[5:0];
          lop[k] = op;
        end else if (st) begin
          if (op == MEM_B || op == MEM_BU) mb[k][addr[5:0]] = mw[7:0];
          else if (op == MEM_H || op == MEM_HU) begin
            b = addr[5:0] & 6'h3e;
            mb[k][b] = mw[7:0];
            mb[k][b + 6'd1] = mw[15:8];
          end else if (op == MEM_W) begin
            b = addr[5:0] & 6'h3c;
            for (int j = 0; j < 4; j++) mb[k][b + 6'(j)] = mw[8*j +: 8];
          end
        end
      end
      if (act[k] && cyc == xs[k]) begin
        b = la[k] & 6'h3c;
        w = {mb[k][b + 6'd3], mb[k][b + 6'd2], mb[k][b + 6'd1], mb[k][b]};
        ew[k] = (lop[k] == MEM_B || lop[k] == MEM_BU) ? w >> (8 * la[k][1:0]) :
                (lop[k] == MEM_H || lop[k] == MEM_HU) ? w >> (16 * la[k][1]) : w;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      logic g_r, g_b, g_e, e_r, e_b;
      logic [3:0] g_d, e_d;
      g_r = k == 0 ? b0.load_data_ready : b2.load_data_ready;
      g_d = k == 0 ? b0.load_data : b2.load_data;
      g_b = k == 0 ? b0.busy : b2.busy;
      g_e = k == 0 ? b0.err : b2.err;
      e_b = act[k] && cyc <= xe[k];
      e_r = act[k] && cyc >= xs[k] && cyc <= xe[k];
      e_d = e_r ? ew[k][4 * (cyc - xs[k]) +: 4] : 4'h0;
      vectors++;
      if ({g_r, g_d, g_b, g_e} !== {e_r, e_d, e_b, eerr[k]}) begin
        miscompares++;
        $display("FAIL cycle u%0d cyc=%0d: got rdy=%b data=%h busy=%b err=%b, want rdy=%b data=%h busy=%b err=%b",
                 lat[k], cyc, g_r, g_d, g_b, g_e, e_r, e_d, e_b, eerr[k]);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  task automatic req(input logic [27:0] a, input logic [2:0] o, input bit l, input bit s, input logic [31:0] w);
    while (counter != 3'd0) @(negedge clk);
    mw = w;
    for (int i = 0; i < 8; i++) begin
      sd = w[4*i +: 4];
      if (i == 7) begin
        addr = a;
        op = o;
        ld = l;
        st = s;
        ar = 1;
      end
      @(negedge clk);
    end
    ar = 0;
    ld = 0;
    st = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic grab(input bit u, output logic [31:0] g);
    int n = 0;
    while ((u ? b2.load_data_ready : b0.load_data_ready) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lastwait = n;
    for (int i = 0; i < 8; i++) begin
      g[4*i +: 4] = u ? b2.load_data : b0.load_data;
      @(negedge clk);
    end
  endtask
  initial begin
    logic [31:0] g;
    idle(3);
    chk("reset_outputs", 32'({b0.load_data_ready, b0.load_data, b0.busy, b0.err,
                              b2.load_data_ready, b2.load_data, b2.busy, b2.err}), 32'h0);
    rstn = 1;
    idle(2);
    req(28'h1000008, MEM_W, 0, 1, 32'hDEADBEEF);
    req(28'h1000008, MEM_W, 1, 0, 32'h0);
    grab(0, g);
    chk("word_load_lat0", g, 32'hDEADBEEF);
    grab(1, g);
    chk("word_load_lat2", g, 32'hDEADBEEF);
    idle(10);
    req(28'h1000004, MEM_W, 0, 1, 32'h11223344);
    req(28'h1000005, MEM_B, 0, 1, 32'h0000005A);
    req(28'h1000004, MEM_W, 1, 0, 32'h0);
    grab(0, g);
    chk("byte_store_word", g, 32'h11225A44);
    idle(30);
    req(28'h1000005, MEM_B, 1, 0, 32'h0);
    grab(0, g);
    chk("byte_load", g, 32'h0011225A);
    idle(30);
    req(28'h1000007, MEM_BU, 1, 0, 32'h0);
    grab(0, g);
    chk("byteu_load_lane3", g, 32'h00000011);
    idle(30);
    req(28'h1000000, MEM_W, 0, 1, 32'h12345678);
    req(28'h1000002, MEM_H, 0, 1, 32'h0000BEEF);
    req(28'h1000000, MEM_W, 1, 0, 32'h0);
    grab(0, g);
    chk("half_store_a2", g, 32'hBEEF5678);
    idle(30);
    req(28'h1000000, MEM_W, 0, 1, 32'h12345678);
    req(28'h1000003, MEM_H, 0, 1, 32'h0000BEEF);
    req(28'h1000002, MEM_H, 1, 0, 32'h0);
    grab(0, g);
    chk("half_store_a3_load", g, 32'h0000BEEF);
    idle(30);
    req(28'h1000008, MEM_W, 1, 0, 32'h0);
    chk("busy_rise_lat2", 32'(b2.busy), 32'd1);
    grab(1, g);
    chk("latency_lat2", 32'(lastwait), 32'd16);
    chk("data_lat2", g, 32'hDEADBEEF);
    idle(10);
    req(28'h1000004, MEM_W, 1, 0, 32'h0);
    req(28'h1000000, MEM_W, 1, 0, 32'h0);
    chk("err_in_wait", 32'(b2.err), 32'd1);
    req(28'h2000008, MEM_W, 1, 0, 32'h0);
    chk("unselected_no_err", 32'(b2.err), 32'd0);
    grab(1, g);
    chk("load_after_err", g, 32'h11225A44);
    idle(20);
    req(28'h1000008, MEM_W, 1, 0, 32'h0);
    idle(3);
    rstn = 0;
    @(negedge clk);
    chk("reset_in_xfer", 32'({b0.load_data_ready, b0.busy, b2.busy}), 32'h0);
    rstn = 1;
    idle(2);
    req(28'h1000004, MEM_W, 1, 0, 32'h0);
    grab(0, g);
    chk("load_after_reset", g, 32'h11225A44);
    idle(30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
